bit_timer: RTL and testbench

// Bit-period timing stage for the serial receive path.

---
 rtl/bit_timer.sv | 84 ++++++++
 tb/tb_bit_timer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_timer.sv
// Bit-period timer for the serial receive path: mid-bit shift strobes for
// NUM_BITS bits per packet, then a one-cycle packet_done.
module bit_timer #(
  parameter int unsigned NUM_BITS = 9
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable_timer,
  input  logic [7:0] bit_period,
  output logic       shift_strobe,
  output logic       packet_done,
  output logic       busy,
  output logic [3:0] bit_index
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam logic [3:0] LAST_BIT = 4'(NUM_BITS - 1);

  state_t     r_state,   w_state_nxt;
  logic [7:0] r_clk_cnt, w_clk_cnt_nxt;
  logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_per_q,   w_per_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_per_q   <= 8'd2;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_per_q   <= w_per_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_per_nxt     = r_per_q;
    case (r_state)
      IDLE: begin
        if (enable_timer) begin
          w_state_nxt   = COUNT;
          // Periods below 2 would leave no distinct mid-point, so clamp to 2.
          w_per_nxt     = (bit_period < 8'd2) ? 8'd2 : bit_period;
          w_clk_cnt_nxt = 8'd1;
          w_bit_cnt_nxt = '0;
        end
      end
      COUNT: begin
        if (!enable_timer) begin
          w_state_nxt   = IDLE;
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
        end else if (r_clk_cnt == r_per_q) begin
          w_clk_cnt_nxt = 8'd1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = DONE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 8'd1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign shift_strobe = (r_state == COUNT) && (r_clk_cnt == (r_per_q >> 1));
  assign packet_done  = (r_state == DONE);
  assign busy         = (r_state != IDLE);
  assign bit_index    = r_bit_cnt;

endmodule

// File: tb/tb_bit_timer.sv
// Self-checking bench for bit_timer: cycle-accurate expectations derived from
// elapsed-clock arithmetic since packet start.
module tb_bit_timer;

  localparam int N = 9;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       enable_timer;
  logic [7:0] bit_period;
  logic       shift_strobe;
  logic       packet_done;
  logic       busy;
  logic [3:0] bit_index;
  logic [6:0] obs;

  int errors = 0;
  int checks = 0;

  // Reference model: elapsed edges since start and the latched period.
  bit m_act;
  int m_t;
  int m_p;
  int m_idle_idx;

  bit_timer #(.NUM_BITS(N)) dut (
    .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer),
    .bit_period(bit_period), .shift_strobe(shift_strobe),
    .packet_done(packet_done), .busy(busy), .bit_index(bit_index)
  );

  always #5 clk = ~clk;
  assign obs = {busy, packet_done, shift_strobe, bit_index};

  task automatic model_reset();
    m_act = 1'b0; m_t = 0; m_p = 2; m_idle_idx = 0;
  endtask

  task automatic model_step();
    if (!m_act) begin
      if (enable_timer) begin
        m_act = 1'b1; m_t = 0;
        m_p = (bit_period < 2) ? 2 : int'(bit_period);
      end
    end else if (m_t == N * m_p) begin
      m_act = 1'b0; m_idle_idx = N - 1;
    end else if (!enable_timer) begin
      m_act = 1'b0; m_idle_idx = 0;
    end else begin
      m_t++;
    end
  endtask

  // {busy, packet_done, shift_strobe, bit_index}
  function automatic logic [6:0] model_out();
    if (!m_act) return {3'b000, 4'(m_idle_idx)};
    if (m_t == N * m_p) return {3'b110, 4'(N - 1)};
    return {1'b1, 1'b0, ((m_t % m_p) + 1 == m_p / 2), 4'(m_t / m_p)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; enable_timer = 1'b0; bit_period = 8'd10;
    model_reset();
    #12;
    checks++;
    if (obs !== 7'd0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, 7'd0);
    end
    @(negedge clk); n_rst = 1'b1;
    cycle();
    checks++;
    if (obs !== model_out()) begin
      errors++; $display("FAIL reset_idle got=%b exp=%b", obs, model_out());
    end
  endtask

  task automatic test_period10();
    int strobes = 0, dones = 0, done_at = -1;
    enable_timer = 1'b1; bit_period = 8'd10;
    for (int i = 0; i <= 91; i++) begin
      cycle();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL p10 cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      if (shift_strobe) strobes++;
      if (packet_done) begin dones++; done_at = i; end
    end
    enable_timer = 1'b0;
    cycle();
    checks++;
    if (strobes !== N) begin errors++; $display("FAIL p10_strobes got=%0d exp=%0d", strobes, N); end
    checks++;
    if (dones !== 1 || done_at !== 90) begin
      errors++; $display("FAIL p10_done got count=%0d at=%0d exp count=1 at=90", dones, done_at);
    end
  endtask

  task automatic test_min_period();
    for (int v = 0; v < 2; v++) begin
      int strobes = 0, done_at = -1;
      enable_timer = 1'b1; bit_period = 8'(v);
      for (int i = 0; i <= 19; i++) begin
        cycle();
        checks++;
        if (obs !== model_out()) begin
          errors++; $display("FAIL pmin%0d cyc=%0d got=%b exp=%b", v, i, obs, model_out());
        end
        if (shift_strobe) strobes++;
        if (packet_done) done_at = i;
      end
      enable_timer = 1'b0;
      cycle();
      checks++;
      if (strobes !== N || done_at !== 18) begin
        errors++; $display("FAIL pmin%0d_summary got strobes=%0d done=%0d exp strobes=%0d done=18", v, strobes, done_at, N);
      end
    end
  endtask

  task automatic test_period255();
    int first = -1, strobes = 0;
    enable_timer = 1'b1; bit_period = 8'd255;
    for (int i = 0; i <= N * 255 + 1; i++) begin
      cycle();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL p255 cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      if (shift_strobe) begin strobes++; if (first < 0) first = i; end
    end
    enable_timer = 1'b0;
    cycle();
    checks++;
    if (first !== 126 || strobes !== N) begin
      errors++; $display("FAIL p255_strobes got first=%0d n=%0d exp first=126 n=%0d", first, strobes, N);
    end
  endtask

  task automatic test_abort();
    int p, abort_t, late;
    p = int'($urandom_range(4, 20));
    abort_t = 4 * p + int'($urandom_range(0, p - 1));
    late = 0;
    enable_timer = 1'b1; bit_period = 8'(p);
    for (int i = 0; i <= abort_t + 6; i++) begin
      cycle();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL abort p=%0d cyc=%0d got=%b exp=%b", p, i, obs, model_out());
      end
      if (i > abort_t && (shift_strobe || packet_done || busy)) late++;
      if (i == abort_t) enable_timer = 1'b0;
    end
    checks++;
    if (late !== 0) begin errors++; $display("FAIL abort_quiet got=%0d exp=0", late); end
    // Abort coinciding with the final bit wrap must suppress packet_done.
    late = 0;
    enable_timer = 1'b1; bit_period = 8'd4;
    for (int i = 0; i <= N * 4 + 3; i++) begin
      cycle();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL abort_last cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      if (packet_done) late++;
      if (i == N * 4 - 1) enable_timer = 1'b0;
    end
    checks++;
    if (late !== 0) begin errors++; $display("FAIL abort_last_done got=%0d exp=0", late); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    enable_timer = 1'b1; bit_period = 8'd10;
    for (int i = 0; i <= 129; i++) begin
      cycle();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      if (packet_done) dones++;
      if (i == 25) bit_period = 8'd4;
    end
    enable_timer = 1'b0;
    cycle();
    checks++;
    if (dones !== 2) begin errors++; $display("FAIL b2b_dones got=%0d exp=2", dones); end
  endtask

  task automatic test_async_reset();
    enable_timer = 1'b1; bit_period = 8'd6;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL arst_pre cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
    end
    #3;
    n_rst = 1'b0; enable_timer = 1'b0;
    #1;
    checks++;
    if (obs !== 7'd0) begin errors++; $display("FAIL arst_immediate got=%b exp=%b", obs, 7'd0); end
    model_reset();
    @(negedge clk); n_rst = 1'b1;
    enable_timer = 1'b1;
    for (int i = 0; i <= N * 6 + 1; i++) begin
      cycle();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL arst_post cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
    end
    enable_timer = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int p, abort_t;
      bit_period = 8'($urandom_range(0, 40));
      p = (bit_period < 2) ? 2 : int'(bit_period);
      abort_t = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N * p - 1)) : -1;
      enable_timer = 1'b1;
      for (int i = 0; i <= N * p + 1; i++) begin
        cycle();
        checks++;
        if (obs !== model_out()) begin
          errors++; $display("FAIL rand pkt=%0d p=%0d cyc=%0d got=%b exp=%b", k, p, i, obs, model_out());
        end
        if (i == abort_t || i == N * p) enable_timer = 1'b0;
        if ($urandom_range(0, 7) == 0) bit_period = 8'($urandom);
      end
      enable_timer = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        cycle();
        checks++;
        if (obs !== model_out()) begin
          errors++; $display("FAIL rand_gap pkt=%0d got=%b exp=%b", k, obs, model_out());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_period10();
    test_min_period();
    test_period255();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
